// File: rtl/fabric_clk_pkg.sv
// Shared definitions for the fabric phase-capture block: phase-generator
// mode encodings and one-hot helpers used by the generator and top.
package fabric_clk_pkg;

  localparam int MODE_COUNTER = 0;  // binary index decoded to one-hot
  localparam int MODE_ONEHOT  = 1;  // circular one-hot shift register

  localparam int MAX_CH = 32;

  // True when exactly one bit is set; zero and multi-hot are both illegal.
  function automatic logic onehot_legal(input logic [MAX_CH-1:0] v);
    return ($countones(v) == 1);
  endfunction

  // OR-encode a one-hot vector to its bit index; only meaningful when legal.
  function automatic logic [4:0] onehot_idx(input logic [MAX_CH-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < MAX_CH; i++)
      if (v[i]) r = r | 5'(i);
    return r;
  endfunction

endpackage

// File: rtl/phase_gen.sv
// Phase generator: prescaler, channel index / one-hot ring and illegal-state
// repair. Produces the capture strobe and the active-channel indicator.
module phase_gen
  import fabric_clk_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV    = 1,
  parameter int MODE   = MODE_ONEHOT,
  localparam int IW    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              stb,
  output logic [NUM_CH-1:0] phase,
  output logic [IW-1:0]     index,
  output logic              phase_err
);

  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0]   CH_LAST  = IW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] RING_RST = {{(NUM_CH-1){1'b0}}, 1'b1};

  logic [DW-1:0]     div_cnt;
  logic [NUM_CH-1:0] ring;     // phase register in both modes
  logic [IW-1:0]     idx;      // binary index, authoritative in counter mode
  logic [IW-1:0]     idx_next;
  logic              legal;
  logic              tick;
  logic              err_q;

  // Counter mode builds phase from a decoded index, so it cannot go illegal.
  assign legal    = (MODE == MODE_ONEHOT) ? onehot_legal(MAX_CH'(ring)) : 1'b1;
  assign tick     = en && (div_cnt == DIV_LAST);
  assign stb      = tick && legal;
  assign idx_next = (idx == CH_LAST) ? '0 : idx + IW'(1);

  // Prescaler, phase advance and repair; repair ignores en and skips capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      ring    <= RING_RST;
      idx     <= '0;
      err_q   <= 1'b0;
    end else if (!legal) begin
      div_cnt <= '0;
      ring    <= RING_RST;
      idx     <= '0;
      err_q   <= 1'b1;
    end else begin
      err_q <= 1'b0;
      if (en)
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (stb) begin
        idx <= idx_next;
        if (MODE == MODE_ONEHOT)
          ring <= {ring[NUM_CH-2:0], ring[NUM_CH-1]};
        else
          ring <= RING_RST << idx_next;
      end
    end
  end

  assign phase     = ring;
  assign phase_err = err_q;
  assign index     = (MODE == MODE_ONEHOT) ? IW'(onehot_idx(MAX_CH'(ring))) : idx;

endmodule

// File: rtl/fabric_phase_capture.sv
// Time-multiplexed per-channel data capture. A single-clock phase generator
// selects one channel per strobe; captures are clock enables on clk.
module fabric_phase_capture
  import fabric_clk_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV    = 1,
  parameter int MODE   = MODE_ONEHOT,
  localparam int IW    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] phase,
  output logic              cap_valid,
  output logic [IW-1:0]     cap_ch,
  output logic              wrap,
  output logic              phase_err
);

  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("fabric_phase_capture: NUM_CH must be 2..32");
  end
  if (DIV < 1 || DIV > 256) begin : g_bad_div
    $error("fabric_phase_capture: DIV must be 1..256");
  end
  if (MODE != MODE_COUNTER && MODE != MODE_ONEHOT) begin : g_bad_mode
    $error("fabric_phase_capture: MODE must be 0 or 1");
  end

  localparam logic [IW-1:0] CH_LAST = IW'(NUM_CH - 1);

  logic          stb;
  logic [IW-1:0] pg_index;

  phase_gen #(
    .NUM_CH (NUM_CH),
    .DIV    (DIV),
    .MODE   (MODE)
  ) u_pg (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .stb       (stb),
    .phase     (phase),
    .index     (pg_index),
    .phase_err (phase_err)
  );

  // Per-lane capture: only the lane selected by the (legal) phase loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (stb && phase[k]) dout[k] <= din[k];
    end
  end

  // Capture status pulses; cap_ch holds the last captured channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_ch    <= '0;
      wrap      <= 1'b0;
    end else begin
      cap_valid <= stb;
      wrap      <= stb && (pg_index == CH_LAST);
      if (stb) cap_ch <= pg_index;
    end
  end

endmodule

// File: tb/tb_fabric_phase_capture.sv
// Directed bench for fabric_phase_capture across three configurations.
module tb_fabric_phase_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: NUM_CH=4 DIV=1 MODE=1
  logic       rst_a, en_a, cv_a, wrap_a, perr_a;
  logic [3:0] din_a, dout_a, phase_a;
  logic [1:0] ch_a;
  // B: NUM_CH=3 DIV=3 MODE=0
  logic       rst_b, en_b, cv_b, wrap_b, perr_b;
  logic [2:0] din_b, dout_b, phase_b;
  logic [1:0] ch_b;
  // C: NUM_CH=4 DIV=4 MODE=1
  logic       rst_c, en_c, cv_c, wrap_c, perr_c;
  logic [3:0] din_c, dout_c, phase_c;
  logic [1:0] ch_c;

  fabric_phase_capture #(.NUM_CH(4), .DIV(1), .MODE(1)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .din(din_a), .dout(dout_a), .phase(phase_a),
    .cap_valid(cv_a), .cap_ch(ch_a), .wrap(wrap_a), .phase_err(perr_a));

  fabric_phase_capture #(.NUM_CH(3), .DIV(3), .MODE(0)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .din(din_b), .dout(dout_b), .phase(phase_b),
    .cap_valid(cv_b), .cap_ch(ch_b), .wrap(wrap_b), .phase_err(perr_b));

  fabric_phase_capture #(.NUM_CH(4), .DIV(4), .MODE(1)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .din(din_c), .dout(dout_c), .phase(phase_c),
    .cap_valid(cv_c), .cap_ch(ch_c), .wrap(wrap_c), .phase_err(perr_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1; rst_c = 1;
    en_a = 1; en_b = 1; en_c = 1;
    din_a = 4'b1010; din_b = 3'b101; din_c = 4'b1111;
    tick(); tick();
    checks++; if (phase_a !== 4'b0001) begin errors++; $display("FAIL rst_phase_a got %b want 0001", phase_a); end
    checks++; if (dout_a !== 4'b0000) begin errors++; $display("FAIL rst_dout_a got %b want 0000", dout_a); end
    checks++; if (cv_a !== 1'b0 || wrap_a !== 1'b0 || perr_a !== 1'b0) begin errors++; $display("FAIL rst_pulses_a got %b%b%b want 000", cv_a, wrap_a, perr_a); end
    checks++; if (ch_a !== 2'd0) begin errors++; $display("FAIL rst_cap_ch_a got %0d want 0", ch_a); end
    checks++; if (phase_b !== 3'b001) begin errors++; $display("FAIL rst_phase_b got %b want 001", phase_b); end
    checks++; if (phase_c !== 4'b0001 || dout_c !== 4'b0000) begin errors++; $display("FAIL rst_c got phase %b dout %b want 0001 0000", phase_c, dout_c); end
  endtask

  task automatic test_rotate();
    rst_a = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (cv_a !== 1'b1 || ch_a !== 2'(i % 4)) begin errors++; $display("FAIL rotate_cap i=%0d got v%b ch%0d want v1 ch%0d", i, cv_a, ch_a, i % 4); end
      checks++; if (wrap_a !== (i == 3)) begin errors++; $display("FAIL rotate_wrap i=%0d got %b want %b", i, wrap_a, (i == 3)); end
      checks++; if (phase_a !== 4'(1 << ((i + 1) % 4))) begin errors++; $display("FAIL rotate_phase i=%0d got %b want %b", i, phase_a, 4'(1 << ((i + 1) % 4))); end
      if (i == 3) begin
        checks++; if (dout_a !== 4'b1010) begin errors++; $display("FAIL rotate_dout got %b want 1010", dout_a); end
      end
    end
  endtask

  task automatic test_fault();
    logic [3:0] held;
    held = dout_a;
    din_a = 4'b0101;
    force dut_a.u_pg.ring = 4'b0110;
    #1;
    release dut_a.u_pg.ring;
    tick();
    checks++; if (phase_a !== 4'b0001) begin errors++; $display("FAIL fault_phase got %b want 0001", phase_a); end
    checks++; if (perr_a !== 1'b1 || cv_a !== 1'b0) begin errors++; $display("FAIL fault_pulse got err%b v%b want err1 v0", perr_a, cv_a); end
    checks++; if (dout_a !== held) begin errors++; $display("FAIL fault_dout got %b want %b", dout_a, held); end
    tick();
    checks++; if (perr_a !== 1'b0 || cv_a !== 1'b1 || ch_a !== 2'd0) begin errors++; $display("FAIL fault_recover got err%b v%b ch%0d want err0 v1 ch0", perr_a, cv_a, ch_a); end
    checks++; if (dout_a !== {held[3:1], 1'b1}) begin errors++; $display("FAIL fault_recap got %b want %b", dout_a, {held[3:1], 1'b1}); end
  endtask

  task automatic test_div3();
    rst_b = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++; if (cv_b !== (n % 3 == 0)) begin errors++; $display("FAIL div3_valid n=%0d got %b want %b", n, cv_b, (n % 3 == 0)); end
      if (n % 3 == 0) begin
        checks++; if (ch_b !== 2'((n / 3 - 1) % 3)) begin errors++; $display("FAIL div3_ch n=%0d got %0d want %0d", n, ch_b, (n / 3 - 1) % 3); end
      end
      checks++; if (wrap_b !== (n == 9)) begin errors++; $display("FAIL div3_wrap n=%0d got %b want %b", n, wrap_b, (n == 9)); end
      checks++; if (dut_b.u_pg.index === 2'd3) begin errors++; $display("FAIL div3_index n=%0d got 3 want <3", n); end
    end
    checks++; if (dout_b !== 3'b101) begin errors++; $display("FAIL div3_dout got %b want 101", dout_b); end
  endtask

  task automatic test_en_hold();
    rst_c = 0;
    tick(); tick();
    checks++; if (cv_c !== 1'b0) begin errors++; $display("FAIL hold_pre got %b want 0", cv_c); end
    en_c = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (cv_c !== 1'b0 || phase_c !== 4'b0001 || dout_c !== 4'b0000) begin errors++; $display("FAIL hold i=%0d got v%b ph%b d%b want v0 ph0001 d0000", i, cv_c, phase_c, dout_c); end
    end
    en_c = 1;
    tick();
    checks++; if (cv_c !== 1'b0) begin errors++; $display("FAIL hold_resume1 got %b want 0", cv_c); end
    tick();
    checks++; if (cv_c !== 1'b1 || ch_c !== 2'd0 || dout_c !== 4'b0001) begin errors++; $display("FAIL hold_resume2 got v%b ch%0d d%b want v1 ch0 d0001", cv_c, ch_c, dout_c); end
  endtask

  task automatic test_reset_mid();
    tick(); tick(); tick();
    rst_c = 1;
    tick();
    checks++; if (phase_c !== 4'b0001 || dout_c !== 4'b0000) begin errors++; $display("FAIL midrst_state got ph%b d%b want 0001 0000", phase_c, dout_c); end
    checks++; if (cv_c !== 1'b0 || wrap_c !== 1'b0 || perr_c !== 1'b0 || ch_c !== 2'd0) begin errors++; $display("FAIL midrst_out got v%b w%b e%b ch%0d want 0 0 0 0", cv_c, wrap_c, perr_c, ch_c); end
    rst_c = 0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      checks++; if (cv_c !== (n == 4) || (n == 4 && ch_c !== 2'd0)) begin errors++; $display("FAIL midrst_first n=%0d got v%b ch%0d want v%b ch0", n, cv_c, ch_c, (n == 4)); end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_a;
    logic [2:0] exp_b;
    int k_a, k_b, cnt_b;
    logic s_a, s_b;
    rst_a = 1; rst_b = 1;
    tick();
    rst_a = 0; rst_b = 0;
    exp_a = '0; exp_b = '0; k_a = 0; k_b = 0; cnt_b = 0;
    for (int i = 0; i < 10000; i++) begin
      din_a = 4'($urandom); en_a = ($urandom_range(0, 3) != 0);
      din_b = 3'($urandom); en_b = ($urandom_range(0, 3) != 0);
      s_a = en_a;
      s_b = en_b && (cnt_b == 2);
      if (s_a) exp_a[k_a] = din_a[k_a];
      if (s_b) exp_b[k_b] = din_b[k_b];
      tick();
      checks++; if (cv_a !== s_a || dout_a !== exp_a || (s_a && ch_a !== 2'(k_a))) begin errors++; $display("FAIL rand_a i=%0d got v%b d%b ch%0d want v%b d%b ch%0d", i, cv_a, dout_a, ch_a, s_a, exp_a, k_a); end
      checks++; if (cv_b !== s_b || dout_b !== exp_b || (s_b && ch_b !== 2'(k_b))) begin errors++; $display("FAIL rand_b i=%0d got v%b d%b ch%0d want v%b d%b ch%0d", i, cv_b, dout_b, ch_b, s_b, exp_b, k_b); end
      if (s_a) k_a = (k_a + 1) % 4;
      if (en_b) cnt_b = (cnt_b == 2) ? 0 : cnt_b + 1;
      if (s_b) k_b = (k_b + 1) % 3;
      checks++; if (phase_a !== 4'(1 << k_a) || phase_b !== 3'(1 << k_b) || perr_a !== 1'b0) begin errors++; $display("FAIL rand_phase i=%0d got a%b b%b e%b want a%b b%b e0", i, phase_a, phase_b, perr_a, 4'(1 << k_a), 3'(1 << k_b)); end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_fault();
    test_div3();
    test_en_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fabric_phase_capture.md
FABRIC_PHASE_CAPTURE -- requirements
Module: fabric_phase_capture

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of capture channels (legal 2..32).
REQ-002 SHALL have parameter DIV, default 1, clk cycles per phase step (legal 1..256).
REQ-003 SHALL have parameter MODE, default 1, phase generator: 0 = binary counter decoded to one-hot, 1 = one-hot circular shift register.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  advance enable; low freezes prescaler and phase.
REQ-007 SHALL have port din  input  NUM_CH  per-channel data.
REQ-008 SHALL have port dout  output  NUM_CH  per-channel captured data, registered.
REQ-009 SHALL have port phase  output  NUM_CH  one-hot active-channel indicator, registered.
REQ-010 SHALL have port cap_valid  output  1  one-cycle pulse, a capture happened last edge.
REQ-011 SHALL have port cap_ch  output  $clog2(NUM_CH)  index of channel captured; valid with cap_valid.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse, coincident with cap_valid when cap_ch == NUM_CH-1.
REQ-013 SHALL have port phase_err  output  1  one-cycle pulse, illegal phase state detected and repaired.

Function
REQ-014 SHALL use no derived signal as a clock; every capture is a clock-enable on clk.
REQ-015 Prescaler div_cnt SHALL count 0..DIV-1 while en=1, wrapping to 0; holds when en=0; width max(1,$clog2(DIV)).
REQ-016 Strobe stb SHALL be en && div_cnt==DIV-1 (DIV=1: stb = en every cycle).
REQ-017 On stb with legal phase and active index k: dout[k] <= din[k]; other dout bits hold.
REQ-018 On same stb, phase SHALL rotate: bit k -> bit (k+1) mod NUM_CH.
REQ-019 cap_valid SHALL be 1 for exactly the cycle after each stb capture; cap_ch = k; latency din->dout = 1 clk.
REQ-020 wrap SHALL pulse with cap_valid when k = NUM_CH-1; next capture is channel 0.
REQ-021 MODE 0: index counter 0..NUM_CH-1 wraps at NUM_CH-1 (not power of two); phase = decode(index), always legal.
REQ-022 MODE 1: phase not exactly one-hot (zero or multi-hot) SHALL be illegal; next edge forces phase to bit0, performs no capture, no cap_valid, pulses phase_err for 1 cycle; div_cnt resets to 0.
REQ-023 Illegal-state repair SHALL occur regardless of en.
REQ-024 en deasserted mid-phase SHALL hold div_cnt, phase, dout; on re-assert counting resumes from held div_cnt.
REQ-025 cap_valid, wrap, phase_err SHALL be 0 whenever not pulsing.

Reset
REQ-026 rst=1 at edge: phase = {0..,1} (channel 0), index = 0, div_cnt = 0, dout = 0, cap_valid = wrap = phase_err = 0, cap_ch = 0.
REQ-027 rst SHALL dominate en, stb and repair in the same cycle; reset mid-phase discards pending capture.
REQ-028 First capture after rst deassert with en=1 SHALL be channel 0, DIV edges after deassert.

Structure
REQ-029 Shared package fabric_clk_pkg SHALL hold MODE encodings (MODE_COUNTER=0, MODE_ONEHOT=1) and function onehot_legal.
REQ-030 One sub-module phase_gen (prescaler + index/ring + repair) SHALL drive stb, phase, index, phase_err; top holds capture regs and outputs.
REQ-031 Parameter legality SHALL be checked at elaboration (out of range -> elaboration error).

Verification
REQ-032 NUM_CH=4, DIV=1, MODE=1, en=1, din=4'b1010 held, after rst: cap_ch 0,1,2,3,0; dout 4'b1010 after 4 captures; wrap on 4th.
REQ-033 NUM_CH=3, DIV=3, MODE=0: cap_valid every 3rd cycle; cap_ch 0,1,2,0; wrap every 9 cycles; index never 3.
REQ-034 MODE=1, force phase=4'b0110 one cycle: next cycle phase=4'b0001, phase_err=1, cap_valid=0, dout unchanged.
REQ-035 DIV=4, drop en at div_cnt=2 for 5 cycles: no cap_valid during hold; capture exactly 2 enabled cycles after re-assert.
REQ-036 Assert rst at div_cnt=DIV-1 with en=1: no capture that edge, all outputs at reset values next cycle, next cap_ch=0.
REQ-037 Random din, 10k cycles, both MODEs: scoreboard dout[k]==din[k] sampled at stb; phase always one-hot outside injected faults.
